// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared state encoding, counter width and address-wrap helper
// for the memory access unit. Rev 1.0
`default_nettype none

package mem_access_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  // Wraps at the last legal word rather than at the bus width.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [31:0] depth);
    return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wait_state_counter.sv
// wait_state_counter: loadable down-counter that paces RAM wait states,
// with zero and one flags. Rev 1.0
`default_nettype none

module wait_state_counter
  import mem_access_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o,
  output logic             one_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);
  assign one_o  = (cnt_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// mem_access_unit: MAR/MDR owner between control unit and single-port RAM;
// adds wait states, bounds check, MAR post-increment and busy/done handshake. Rev 1.0
`default_nettype none

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic                  addr_sel_i,
  input  logic                  inc_i,
  input  logic [ADDR_WIDTH-1:0] addr_in_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [ADDR_WIDTH-1:0] mar_q_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  inc_q, inc_d;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  addr_oob;
  logic                  cnt_zero;
  logic                  cnt_one;

  assign sel_addr = addr_sel_i ? mar_q : addr_in_i;
  assign addr_oob = (32'(sel_addr) >= 32'(DEPTH));

  wait_state_counter u_wait_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (state_q == ST_ACCESS),
    .en_i       (state_q == ST_WAIT),
    .load_val_i (CNT_W'(WAIT_STATES)),
    .zero_o     (cnt_zero),
    .one_o      (cnt_one)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      inc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      inc_q   <= inc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mar_d    = mar_q;
    mdr_d    = mdr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    inc_d    = inc_q;
    busy_o   = 1'b1;
    done_o   = 1'b0;
    err_o    = 1'b0;
    mem_we_o = 1'b0;
    mem_re_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (req_i) begin
          mar_d   = sel_addr;
          we_d    = we_i;
          inc_d   = inc_i;
          wdata_d = wdata_i;
          state_d = addr_oob ? ST_ERR : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_re_o = !we_q;
        mem_we_o = we_q;
        if (WAIT_STATES > 0) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_DONE;
          if (!we_q) mdr_d = mem_rdata_i;
        end
      end
      ST_WAIT: begin
        // The zero term only guards against a stuck WAIT; normal exit is on one.
        if (cnt_one || cnt_zero) begin
          if (!we_q) mdr_d = mem_rdata_i;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o = 1'b1;
        if (inc_q) mar_d = ADDR_WIDTH'(next_addr(32'(mar_q), 32'(DEPTH)));
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        done_o  = 1'b1;
        err_o   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rdata_o     = mdr_q;
  assign mar_q_o     = mar_q;
  assign mem_addr_o  = mar_q;
  assign mem_wdata_o = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench driving four unit instances (different
// wait-state settings, DEPTH = 200) against a shared behavioural RAM.
`default_nettype none

module tb_mem_access_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req, we, addr_sel, inc;
  logic [7:0] addr_in, wdata;

  logic       busy [4];
  logic       done [4];
  logic       err [4];
  logic       mem_we [4];
  logic       mem_re [4];
  logic [7:0] rdata [4];
  logic [7:0] mar [4];
  logic [7:0] mem_addr [4];
  logic [7:0] mem_wdata [4];
  logic [7:0] mem_rdata [4];

  logic [7:0] ram [256];
  logic       tb_we;
  logic [7:0] tb_waddr, tb_wdata;

  int n_cmp = 0;
  int n_err = 0;
  int n_done;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_we) ram[tb_waddr] <= tb_wdata;
    else for (int k = 0; k < 4; k++) if (mem_we[k]) ram[mem_addr[k]] <= mem_wdata[k];
  end

  assign mem_rdata[0] = ram[mem_addr[0]];
  assign mem_rdata[1] = ram[mem_addr[1]];
  assign mem_rdata[2] = ram[mem_addr[2]];
  assign mem_rdata[3] = ram[mem_addr[3]];

  mem_access_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(1)) u_w1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_sel_i(addr_sel), .inc_i(inc),
    .addr_in_i(addr_in), .wdata_i(wdata), .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]),
    .rdata_o(rdata[0]), .mar_q_o(mar[0]), .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
    .mem_we_o(mem_we[0]), .mem_re_o(mem_re[0]), .mem_rdata_i(mem_rdata[0]));

  mem_access_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(0)) u_w0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_sel_i(addr_sel), .inc_i(inc),
    .addr_in_i(addr_in), .wdata_i(wdata), .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]),
    .rdata_o(rdata[1]), .mar_q_o(mar[1]), .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
    .mem_we_o(mem_we[1]), .mem_re_o(mem_re[1]), .mem_rdata_i(mem_rdata[1]));

  mem_access_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(2)) u_w2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_sel_i(addr_sel), .inc_i(inc),
    .addr_in_i(addr_in), .wdata_i(wdata), .busy_o(busy[2]), .done_o(done[2]), .err_o(err[2]),
    .rdata_o(rdata[2]), .mar_q_o(mar[2]), .mem_addr_o(mem_addr[2]), .mem_wdata_o(mem_wdata[2]),
    .mem_we_o(mem_we[2]), .mem_re_o(mem_re[2]), .mem_rdata_i(mem_rdata[2]));

  mem_access_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(15)) u_w15 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .addr_sel_i(addr_sel), .inc_i(inc),
    .addr_in_i(addr_in), .wdata_i(wdata), .busy_o(busy[3]), .done_o(done[3]), .err_o(err[3]),
    .rdata_o(rdata[3]), .mar_q_o(mar[3]), .mem_addr_o(mem_addr[3]), .mem_wdata_o(mem_wdata[3]),
    .mem_we_o(mem_we[3]), .mem_re_o(mem_re[3]), .mem_rdata_i(mem_rdata[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit any_busy();
    return busy[0] || busy[1] || busy[2] || busy[3];
  endfunction

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && any_busy(); i++) tick();
    chk(tag, {31'd0, any_busy()}, 32'd0);
  endtask

  task automatic ram_wr(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic issue(input logic w, input logic sel, input logic i, input logic [7:0] a, input logic [7:0] d);
    we = w; addr_sel = sel; inc = i; addr_in = a; wdata = d; req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr_sel = 1'b0; inc = 1'b0;
    addr_in = '0; wdata = '0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy[0]}, 32'd0);
    chk("rst_done", {31'd0, done[0]}, 32'd0);
    chk("rst_mar", {24'd0, mar[0]}, 32'd0);
    chk("rst_rdata", {24'd0, rdata[0]}, 32'd0);
    rst_n = 1'b1;
    ram_wr(8'h10, 8'hA5);
    ram_wr(8'd198, 8'h11);
    ram_wr(8'd199, 8'h22);
    ram_wr(8'h40, 8'h5A);

    // Reset lands in the middle of a write access.
    issue(1'b1, 1'b0, 1'b0, 8'h30, 8'h77);
    chk("abort_we_before", {31'd0, mem_we[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_drop", {31'd0, mem_we[0]}, 32'd0);
    chk("abort_busy", {31'd0, busy[0]}, 32'd0);
    chk("abort_mar", {24'd0, mar[0]}, 32'd0);
    rst_n = 1'b1;
    tick();

    issue(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
    chk("rd_re_c1", {31'd0, mem_re[0]}, 32'd1);
    chk("rd_addr_c1", {24'd0, mem_addr[0]}, 32'h10);
    tick();
    chk("rd_done_c2", {31'd0, done[0]}, 32'd0);
    chk("w0_done_c2", {31'd0, done[1]}, 32'd1);
    chk("rd_re_wait", {31'd0, mem_re[0]}, 32'd0);
    tick();
    chk("rd_done_c3", {31'd0, done[0]}, 32'd1);
    chk("rd_err_c3", {31'd0, err[0]}, 32'd0);
    chk("rd_rdata", {24'd0, rdata[0]}, 32'hA5);
    wait_idle("idle_1");

    issue(1'b1, 1'b0, 1'b0, 8'h05, 8'h3C);
    chk("wr_we_c1", {31'd0, mem_we[1]}, 32'd1);
    chk("wr_addr_c1", {24'd0, mem_addr[1]}, 32'h05);
    chk("wr_wdata_c1", {24'd0, mem_wdata[1]}, 32'h3C);
    tick();
    chk("wr_done_c2", {31'd0, done[1]}, 32'd1);
    chk("wr_we_c2", {31'd0, mem_we[1]}, 32'd0);
    chk("wr_rdata_keep", {24'd0, rdata[1]}, 32'hA5);
    wait_idle("idle_2");
    issue(1'b0, 1'b0, 1'b0, 8'h05, 8'h00);
    tick();
    chk("rb_done_c2", {31'd0, done[1]}, 32'd1);
    chk("rb_rdata", {24'd0, rdata[1]}, 32'h3C);
    wait_idle("idle_3");

    issue(1'b0, 1'b0, 1'b1, 8'd198, 8'h00);
    chk("inc1_addr", {24'd0, mem_addr[2]}, 32'd198);
    tick(); tick();
    chk("inc1_done_c3", {31'd0, done[2]}, 32'd0);
    tick();
    chk("inc1_done_c4", {31'd0, done[2]}, 32'd1);
    chk("inc1_rdata", {24'd0, rdata[2]}, 32'h11);
    chk("inc1_mar_done", {24'd0, mar[2]}, 32'd198);
    tick();
    chk("inc1_mar_after", {24'd0, mar[2]}, 32'd199);
    wait_idle("idle_4");
    issue(1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
    chk("inc2_addr", {24'd0, mem_addr[2]}, 32'd199);
    tick(); tick(); tick();
    chk("inc2_done_c4", {31'd0, done[2]}, 32'd1);
    chk("inc2_rdata", {24'd0, rdata[2]}, 32'h22);
    tick();
    chk("inc2_mar_wrap", {24'd0, mar[2]}, 32'd0);
    wait_idle("idle_5");

    issue(1'b0, 1'b0, 1'b0, 8'd200, 8'h00);
    chk("oob_done", {31'd0, done[0]}, 32'd1);
    chk("oob_err", {31'd0, err[0]}, 32'd1);
    chk("oob_re", {31'd0, mem_re[0]}, 32'd0);
    chk("oob_we", {31'd0, mem_we[0]}, 32'd0);
    chk("oob_mar", {24'd0, mar[0]}, 32'd200);
    chk("oob_rdata", {24'd0, rdata[0]}, 32'h22);
    tick();
    chk("oob_busy_c2", {31'd0, busy[0]}, 32'd0);
    wait_idle("idle_6");

    // Extra req pulse while the W=2 unit sits in WAIT.
    issue(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    n_done = int'(done[2]);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_done += int'(done[2]);
    end
    chk("busy_req_dones", n_done, 32'd1);
    wait_idle("idle_7");

    we = 1'b0; addr_sel = 1'b0; inc = 1'b0; addr_in = 8'h10; req = 1'b1;
    tick(); tick();
    tick();
    chk("hold_done_c3", {31'd0, done[0]}, 32'd1);
    tick();
    chk("hold_idle_c4", {31'd0, busy[0]}, 32'd0);
    tick();
    chk("hold_busy_c5", {31'd0, busy[0]}, 32'd1);
    chk("hold_re_c5", {31'd0, mem_re[0]}, 32'd1);
    tick(); tick();
    chk("hold_done_c7", {31'd0, done[0]}, 32'd1);
    req = 1'b0;
    wait_idle("idle_8");

    issue(1'b0, 1'b0, 1'b0, 8'h40, 8'h00);
    repeat (9) tick();
    ram_wr(8'h40, 8'h66);
    repeat (5) tick();
    chk("w15_done_c16", {31'd0, done[3]}, 32'd0);
    ram_wr(8'h40, 8'h99);
    chk("w15_done_c17", {31'd0, done[3]}, 32'd1);
    chk("w15_err_c17", {31'd0, err[3]}, 32'd0);
    chk("w15_rdata", {24'd0, rdata[3]}, 32'h66);
    wait_idle("idle_9");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
